// File: rtl/sift_kp_pkg.sv
// Shared widths, keypoint entry layout and reader FSM states for the SIFT keypoint reader.
package sift_kp_pkg;

  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int KP_W     = 19;
  localparam int ADDR_W   = 11;
  localparam int CNT_W    = 12;
  localparam int IMG_ROWS = 480;
  localparam int IMG_COLS = 640;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             layer;
  } kp_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_DRAIN,
    ST_FIN
  } kp_rd_state_t;

  // SRAM word layout: row in [18:10], column in [9:0].
  function automatic kp_entry_t kp_unpack(input logic [KP_W-1:0] d, input logic layer);
    kp_entry_t e;
    e.row   = d[KP_W-1:COL_W];
    e.col   = d[COL_W-1:0];
    e.layer = layer;
    return e;
  endfunction

endpackage

// File: rtl/kp_out_fifo.sv
// Two-entry synchronous FIFO of keypoint entries; the head is visible combinationally.
module kp_out_fifo
  import sift_kp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  kp_entry_t din_i,
  output kp_entry_t head_o,
  output logic [1:0] count_o,
  output logic      empty_o
);

  kp_entry_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: ;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/keypoint_reader.sv
// Drains keypoint_1 then keypoint_2 SRAMs into a valid/ready keypoint stream.
// Define KP_BORDER_REJECT_EN to drop entries inside the image border margin and count them.
module keypoint_reader
  import sift_kp_pkg::*;
#(
  parameter int ADDR_W   = sift_kp_pkg::ADDR_W,
  parameter int CNT_W    = sift_kp_pkg::CNT_W,
  parameter int IMG_ROWS = sift_kp_pkg::IMG_ROWS,
  parameter int IMG_COLS = sift_kp_pkg::IMG_COLS,
  parameter int BORDER   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  kp1_count,
  input  logic [CNT_W-1:0]  kp2_count,
  output logic [ADDR_W-1:0] kp1_rd_addr,
  input  logic [KP_W-1:0]   kp1_dout,
  output logic [ADDR_W-1:0] kp2_rd_addr,
  input  logic [KP_W-1:0]   kp2_dout,
  output logic              kp_valid,
  input  logic              kp_ready,
  output logic [ROW_W-1:0]  kp_row,
  output logic [COL_W-1:0]  kp_col,
  output logic              kp_layer,
  output logic              busy,
  output logic              done
`ifdef KP_BORDER_REJECT_EN
  ,
  output logic [CNT_W-1:0]  kp_rejected
`endif
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(2 ** ADDR_W);

  if (2 * BORDER >= IMG_ROWS || 2 * BORDER >= IMG_COLS ||
      IMG_ROWS > 2 ** ROW_W || IMG_COLS > 2 ** COL_W) begin : g_bad_geometry
    $error("keypoint_reader: border margin or image size does not fit the entry fields");
  end

  kp_rd_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic [CNT_W-1:0]  sat1, sat2;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              infl_q, infl_d, infl_layer_q, infl_layer_d;
  logic              start_ok, space, last1, last2, drop, push, pop;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [2:0]        occ_after;
  kp_entry_t         rd_entry, head;

  assign start_ok = start && (state_q == ST_IDLE);
  assign sat1     = (kp1_count > MAX_CNT) ? MAX_CNT : kp1_count;
  assign sat2     = (kp2_count > MAX_CNT) ? MAX_CNT : kp2_count;

  assign kp_valid = !fifo_empty;
  assign pop      = kp_valid && kp_ready;

  // Occupancy is taken after this cycle's pop so a read can issue alongside it (1 beat/cycle).
  assign occ_after = 3'(fifo_count) - 3'(pop) + 3'(infl_q);
  assign space     = (occ_after < 3'd2);
  assign last1     = (CNT_W'(addr1_q) == cnt1_q - CNT_W'(1));
  assign last2     = (CNT_W'(addr2_q) == cnt2_q - CNT_W'(1));

  assign rd_entry = kp_unpack(infl_layer_q ? kp2_dout : kp1_dout, infl_layer_q);
  assign push     = infl_q && !drop;

  always_comb begin
    state_d      = state_q;
    cnt1_d       = cnt1_q;
    cnt2_d       = cnt2_q;
    addr1_d      = addr1_q;
    addr2_d      = addr2_q;
    infl_d       = 1'b0;
    infl_layer_d = infl_layer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          cnt1_d  = sat1;
          cnt2_d  = sat2;
          addr1_d = '0;
          addr2_d = '0;
          // An empty pass still spends one busy cycle before FIN.
          if (sat1 != '0)      state_d = ST_RD1;
          else if (sat2 != '0) state_d = ST_RD2;
          else                 state_d = ST_DRAIN;
        end
      end
      ST_RD1: begin
        if (space) begin
          infl_d       = 1'b1;
          infl_layer_d = 1'b0;
          addr1_d      = addr1_q + ADDR_W'(1);
          if (last1) state_d = (cnt2_q != '0) ? ST_RD2 : ST_DRAIN;
        end
      end
      ST_RD2: begin
        if (space) begin
          infl_d       = 1'b1;
          infl_layer_d = 1'b1;
          addr2_d      = addr2_q + ADDR_W'(1);
          if (last2) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!infl_q && occ_after == 3'd0) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt1_q       <= '0;
      cnt2_q       <= '0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      infl_q       <= 1'b0;
      infl_layer_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt1_q       <= cnt1_d;
      cnt2_q       <= cnt2_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      infl_q       <= infl_d;
      infl_layer_q <= infl_layer_d;
    end
  end

  kp_out_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rd_entry),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

`ifdef KP_BORDER_REJECT_EN
  logic [CNT_W-1:0] rej_q, rej_d;

  assign drop = (rd_entry.row <  ROW_W'(BORDER)) ||
                (rd_entry.row >= ROW_W'(IMG_ROWS - BORDER)) ||
                (rd_entry.col <  COL_W'(BORDER)) ||
                (rd_entry.col >= COL_W'(IMG_COLS - BORDER));

  always_comb begin
    rej_d = rej_q;
    if (start_ok)           rej_d = '0;
    else if (infl_q && drop) rej_d = rej_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rej_q <= '0;
    else        rej_q <= rej_d;
  end

  assign kp_rejected = rej_q;
`else
  assign drop = 1'b0;
`endif

  assign kp1_rd_addr = addr1_q;
  assign kp2_rd_addr = addr2_q;
  assign kp_row      = head.row;
  assign kp_col      = head.col;
  assign kp_layer    = head.layer;
  assign busy        = (state_q == ST_RD1) || (state_q == ST_RD2) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_FIN);

endmodule

// File: tb/tb_keypoint_reader.sv
// Randomized bench for keypoint_reader: SRAM models, a list-level reference and a cycle-timing reference.
module tb_keypoint_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] kp1_count, kp2_count;
  logic [10:0] kp1_rd_addr, kp2_rd_addr;
  logic [18:0] kp1_dout, kp2_dout;
  logic        kp_valid, kp_ready;
  logic [8:0]  kp_row;
  logic [9:0]  kp_col;
  logic        kp_layer, busy, done;
`ifdef KP_BORDER_REJECT_EN
  logic [11:0] kp_rejected;
`endif

  logic [18:0] mem1 [2048];
  logic [18:0] mem2 [2048];
  int          exp_q[$];
  int          exp_drop;
  int          n_vec = 0;
  int          n_err = 0;

  keypoint_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kp1_count   (kp1_count),
    .kp2_count   (kp2_count),
    .kp1_rd_addr (kp1_rd_addr),
    .kp1_dout    (kp1_dout),
    .kp2_rd_addr (kp2_rd_addr),
    .kp2_dout    (kp2_dout),
    .kp_valid    (kp_valid),
    .kp_ready    (kp_ready),
    .kp_row      (kp_row),
    .kp_col      (kp_col),
    .kp_layer    (kp_layer),
    .busy        (busy),
    .done        (done)
`ifdef KP_BORDER_REJECT_EN
    ,
    .kp_rejected (kp_rejected)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAMs: data appears one cycle after the address.
  always @(posedge clk) begin
    kp1_dout <= mem1[kp1_rd_addr];
    kp2_dout <= mem2[kp2_rd_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit kp_dropped(input logic [18:0] d);
`ifdef KP_BORDER_REJECT_EN
    int r, c;
    r = int'(d[18:10]);
    c = int'(d[9:0]);
    return (r < 8) || (r >= 480 - 8) || (c < 8) || (c >= 640 - 8);
`else
    return (d === 19'bx);
`endif
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      mem1[i] = 19'($urandom);
      mem2[i] = 19'($urandom);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, kp_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_beat"}, {kp_layer, kp_row, kp_col}, 0);
    check_eq({tag, "_addr"}, {kp1_rd_addr, kp2_rd_addr}, 0);
`ifdef KP_BORDER_REJECT_EN
    check_eq({tag, "_rej"}, kp_rejected, 0);
`endif
  endtask

  // rmode: 0 = always ready, 1 = ready pattern 1,0,0,..., 2 = random ready.
  task automatic run_pass(input int n1, input int n2, input int rmode, input bit restart,
                          input int abort_beats, input bit chk_timing);
    int m1, m2, nb, acc1, acc2, budget, done_cyc, last_cyc;
    bit stall;
    logic [19:0] held, beat;
    m1 = (n1 > 2048) ? 2048 : n1;
    m2 = (n2 > 2048) ? 2048 : n2;
    exp_q.delete();
    exp_drop = 0;
    for (int i = 0; i < m1; i++)
      if (kp_dropped(mem1[i])) exp_drop++; else exp_q.push_back(int'({1'b0, mem1[i]}));
    for (int i = 0; i < m2; i++)
      if (kp_dropped(mem2[i])) exp_drop++; else exp_q.push_back(int'({1'b1, mem2[i]}));
    nb = 0; acc1 = 0; acc2 = 0; done_cyc = -1; last_cyc = -1; stall = 1'b0; held = '0;
    budget = 8 * (m1 + m2) + 40;

    @(negedge clk);
    kp1_count = 12'(n1);
    kp2_count = 12'(n2);
    start     = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start = restart && (cyc == 2);
      if (restart && cyc == 2) begin
        kp1_count = 12'd9;
        kp2_count = 12'd9;
      end
      case (rmode)
        0:       kp_ready = 1'b1;
        1:       kp_ready = ((cyc - 1) % 3 == 0);
        default: kp_ready = 1'($urandom_range(0, 1));
      endcase
      beat = {kp_layer, kp_row, kp_col};
      if (stall) check_eq("hold_stable", beat, held);
      if (exp_drop == 0)
        check_eq("outstanding_le2",
                 32'(((kp1_rd_addr - acc1) & 2047) + ((kp2_rd_addr - acc2) & 2047) <= 2), 1);
      if (kp_valid && kp_ready) begin
        check_eq("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("beat_data", beat, exp_q.pop_front());
        nb++;
        if (kp_layer) acc2++; else acc1++;
        last_cyc = cyc;
        if (chk_timing && exp_drop == 0) check_eq("beat_cycle", cyc, 2 + nb);
      end
      stall = kp_valid && !kp_ready;
      held  = beat;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check_eq("busy_in_pass", busy, 1);
      if (abort_beats > 0 && nb == abort_beats) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("async_reset");
        repeat (3) begin
          @(negedge clk);
          check_eq("no_done_after_abort", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
    end

    check_eq("done_seen", 32'(done_cyc > 0), 1);
    check_eq("beats_missing", exp_q.size(), 0);
    if (done_cyc > 0) begin
      check_eq("busy_at_done", busy, 0);
      check_eq("valid_at_done", kp_valid, 0);
      if (last_cyc > 0 && exp_drop == 0) check_eq("done_after_last", done_cyc, last_cyc + 1);
      if (chk_timing && exp_drop == 0)
        check_eq("done_cycle", done_cyc, (m1 + m2 == 0) ? 2 : 3 + m1 + m2);
`ifdef KP_BORDER_REJECT_EN
      check_eq("rejected", kp_rejected, exp_drop);
`endif
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("busy_after", busy, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    kp_ready  = 1'b0;
    kp1_count = '0;
    kp2_count = '0;
    fill_random(2048);
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_pass(3, 2, 0, 1'b0, 0, 1'b1);
    run_pass(0, 0, 0, 1'b0, 0, 1'b1);
    run_pass(4, 0, 1, 1'b0, 0, 1'b0);
    run_pass(3, 2, 0, 1'b1, 0, 1'b1);
    run_pass(5, 5, 0, 1'b0, 2, 1'b0);
    run_pass(5, 5, 0, 1'b0, 0, 1'b1);
    run_pass(0, 3, 0, 1'b0, 0, 1'b1);

`ifdef KP_BORDER_REJECT_EN
    mem1[0] = {9'd0,   10'd100};
    mem1[1] = {9'd240, 10'd320};
    mem1[2] = {9'd475, 10'd10};
    mem1[3] = {9'd100, 10'd635};
    run_pass(4, 0, 0, 1'b0, 0, 1'b0);
    check_eq("border_drops", exp_drop, 3);
    mem1[0] = {9'd0, 10'd0};
    run_pass(1, 0, 0, 1'b0, 0, 1'b0);
`endif

    for (int k = 0; k < 20; k++) begin
      fill_random(16);
      run_pass($urandom_range(0, 12), $urandom_range(0, 12), 2, 1'b0, 0, 1'b0);
    end

    fill_random(2048);
    run_pass(3000, 1, 0, 1'b0, 0, 1'b1);
    run_pass(2, 4095, 2, 1'b0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
